// File: rtl/sram_arbiter.sv
// Two-port (video / CPU) sequencer for the shared 32-bit asynchronous SRAM on the 12-bit muxed bus.
// Define SRAM_ARB_FAIR_EN to bound consecutive video grants made while the CPU waits.
module sram_arbiter #(
    parameter int unsigned VID_RUN_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_ben,
    input  logic [19:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [17:0] vid_adr,
    output logic [31:0] vid_rdata,
    output logic        vid_ack,
    output logic [11:0] SRabus,
    output logic        SRce,
    output logic        SRoe,
    output logic        SRwe,
    input  logic [31:0] sr_din,
    output logic [31:0] sr_dout,
    output logic        sr_dout_en
);

    localparam int unsigned DW    = 32;
    localparam int unsigned WAW   = 18;
    localparam int unsigned BEW   = 4;
    localparam int unsigned BUSW  = 12;
    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {IDLE, P0, P1, P2} state_t;

    state_t           state_q, state_d;
    logic             port_q, port_d;      // 1 = video owns the access
    logic             wr_q, wr_d;
    logic [WAW-1:0]   wadr_q, wadr_d;
    logic [BEW-1:0]   be_n_q, be_n_d;
    logic             cpu_elig, vid_elig, grant_cpu, grant_vid;
    logic             cpu_ack_d, vid_ack_d;
    logic [DW-1:0]    cpu_rdata_d, vid_rdata_d, sr_dout_d;
    logic [BUSW-1:0]  srabus_d;
    logic             srce_d, sroe_d, srwe_d, sr_dout_en_d;
`ifdef SRAM_ARB_FAIR_EN
    logic [RUN_W-1:0] run_q, run_d;
`endif

    // Next state, access latch and the registered SRAM pins for the state being entered
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        wr_d         = wr_q;
        wadr_d       = wadr_q;
        be_n_d       = be_n_q;
        cpu_ack_d    = 1'b0;
        vid_ack_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata;
        vid_rdata_d  = vid_rdata;
        sr_dout_d    = sr_dout;
        grant_cpu    = 1'b0;
        grant_vid    = 1'b0;
        // a port is not re-granted in the cycle its ack is showing
        cpu_elig     = cpu_req & ~cpu_ack;
        vid_elig     = vid_req & ~vid_ack;
`ifdef SRAM_ARB_FAIR_EN
        run_d        = run_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef SRAM_ARB_FAIR_EN
                if (cpu_elig && (run_q == RUN_W'(VID_RUN_MAX))) grant_cpu = 1'b1;
                else if (vid_elig)                               grant_vid = 1'b1;
                else if (cpu_elig)                               grant_cpu = 1'b1;
                if (!cpu_req || grant_cpu)
                    run_d = '0;
                else if (grant_vid && cpu_elig && (run_q != '1))
                    run_d = run_q + RUN_W'(1);
`else
                if (vid_elig)      grant_vid = 1'b1;
                else if (cpu_elig) grant_cpu = 1'b1;
`endif
                if (grant_vid || grant_cpu) begin
                    state_d = P0;
                    port_d  = grant_vid;
                    wr_d    = grant_cpu & cpu_wr;
                    wadr_d  = grant_vid ? vid_adr : cpu_adr[19:2];
                    be_n_d  = (grant_cpu && cpu_ben) ? ~(BEW'(1) << cpu_adr[1:0]) : '0;
                    if (grant_cpu && cpu_wr) sr_dout_d = cpu_wdata;
                end
            end
            P0: state_d = P1;
            P1: state_d = P2;
            P2: begin
                state_d   = IDLE;
                cpu_ack_d = ~port_q;
                vid_ack_d = port_q;
                if (!wr_q) begin
                    if (port_q) vid_rdata_d = sr_din;
                    else        cpu_rdata_d = sr_din;
                end
            end
            default: state_d = IDLE;
        endcase

        srce_d       = 1'b1;
        sroe_d       = 1'b1;
        srwe_d       = 1'b1;
        sr_dout_en_d = 1'b0;
        srabus_d     = '0;
        case (state_d)
            P0: srabus_d = {2'b00, wadr_d[17:8]};
            P1, P2: begin
                srce_d       = 1'b0;
                srabus_d     = {wadr_d[7:0], be_n_d[2], be_n_d[3], be_n_d[0], be_n_d[1]};
                sroe_d       = wr_d;
                sr_dout_en_d = wr_d;
                srwe_d       = ~(wr_d && (state_d == P2));
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset drops strobes immediately, even mid-access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            port_q     <= 1'b0;
            wr_q       <= 1'b0;
            wadr_q     <= '0;
            be_n_q     <= '0;
            cpu_ack    <= 1'b0;
            vid_ack    <= 1'b0;
            cpu_rdata  <= '0;
            vid_rdata  <= '0;
            sr_dout    <= '0;
            sr_dout_en <= 1'b0;
            SRabus     <= '0;
            SRce       <= 1'b1;
            SRoe       <= 1'b1;
            SRwe       <= 1'b1;
`ifdef SRAM_ARB_FAIR_EN
            run_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            wr_q       <= wr_d;
            wadr_q     <= wadr_d;
            be_n_q     <= be_n_d;
            cpu_ack    <= cpu_ack_d;
            vid_ack    <= vid_ack_d;
            cpu_rdata  <= cpu_rdata_d;
            vid_rdata  <= vid_rdata_d;
            sr_dout    <= sr_dout_d;
            sr_dout_en <= sr_dout_en_d;
            SRabus     <= srabus_d;
            SRce       <= srce_d;
            SRoe       <= sroe_d;
            SRwe       <= srwe_d;
`ifdef SRAM_ARB_FAIR_EN
            run_q      <= run_d;
`endif
        end
    end

endmodule
